// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the program counter, addresses the
// combinational-read instruction ROM and loads the IF/ID pipeline register.
// Priority of controls at each edge: halt > redirect/flush > stall > advance.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic [9:0]  rom_addr,
   input  logic [31:0] rom_data,
   output logic [31:0] pc,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4,
   output logic        if_valid,
   output logic        halted,
   output logic        misalign_err
);

   logic [31:0] r_pc;
   logic [31:0] r_if_instr;
   logic [31:0] r_if_pc;
   logic [31:0] r_if_pc4;
   logic        r_if_valid;
   logic        r_halted;
   logic        r_misalign;

   logic [31:0] w_pc4;
   logic        w_freeze;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_if_instr_nxt;
   logic [31:0] w_if_pc_nxt;
   logic [31:0] w_if_pc4_nxt;
   logic        w_if_valid_nxt;
   logic        w_misalign_nxt;

   // Sequential successor wraps naturally at 2^32.
   assign w_pc4    = r_pc + 32'd4;
   // A halt request freezes fetch on the very edge it is seen.
   assign w_freeze = r_halted | halt;

   // Next-state selection for the PC, IF/ID register and the error flag.
   always_comb begin
      w_pc_nxt       = r_pc;
      w_if_instr_nxt = r_if_instr;
      w_if_pc_nxt    = r_if_pc;
      w_if_pc4_nxt   = r_if_pc4;
      w_if_valid_nxt = r_if_valid;
      w_misalign_nxt = r_misalign;

      // PC: halt holds, redirect wins over stall so a target is never lost.
      if (w_freeze) begin
         w_pc_nxt = r_pc;
      end else if (redirect) begin
         w_pc_nxt = {redirect_pc[31:2], 2'b00};
      end else if (!stall) begin
         w_pc_nxt = w_pc4;
      end

      // IF/ID: halt or flush inserts a bubble, stall holds, else capture.
      if (w_freeze || flush) begin
         w_if_instr_nxt = NOP_INSTR;
         w_if_pc_nxt    = 32'd0;
         w_if_pc4_nxt   = 32'd0;
         w_if_valid_nxt = 1'b0;
      end else if (!stall) begin
         w_if_instr_nxt = rom_data;
         w_if_pc_nxt    = r_pc;
         w_if_pc4_nxt   = w_pc4;
         w_if_valid_nxt = 1'b1;
      end

      // Misaligned targets are flagged once the stage is not already halted.
      if (redirect && !r_halted && (redirect_pc[1:0] != 2'b00)) begin
         w_misalign_nxt = 1'b1;
      end
   end

   // State registers; reset acts immediately, independent of the clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc       <= RESET_PC;
         r_if_instr <= NOP_INSTR;
         r_if_pc    <= 32'd0;
         r_if_pc4   <= 32'd0;
         r_if_valid <= 1'b0;
         r_halted   <= 1'b0;
         r_misalign <= 1'b0;
      end else begin
         r_pc       <= w_pc_nxt;
         r_if_instr <= w_if_instr_nxt;
         r_if_pc    <= w_if_pc_nxt;
         r_if_pc4   <= w_if_pc4_nxt;
         r_if_valid <= w_if_valid_nxt;
         r_halted   <= r_halted | halt;
         r_misalign <= w_misalign_nxt;
      end
   end

   // ROM is word addressed; upper PC bits alias onto the 4 KiB ROM.
   assign rom_addr     = r_pc[11:2];
   assign pc           = r_pc;
   assign if_instr     = r_if_instr;
   assign if_pc        = r_if_pc;
   assign if_pc4       = r_if_pc4;
   assign if_valid     = r_if_valid;
   assign halted       = r_halted;
   assign misalign_err = r_misalign;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM word k holds 32'h1000_0000+k.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        halt;
   logic [9:0]  rom_addr;
   logic [31:0] rom_data;
   logic [31:0] pc;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;
   logic        if_valid;
   logic        halted;
   logic        misalign_err;

   int checks = 0;
   int errors = 0;

   instr_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
      .rom_addr(rom_addr), .rom_data(rom_data), .pc(pc),
      .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
      .if_valid(if_valid), .halted(halted), .misalign_err(misalign_err)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction ROM contents
   assign rom_data = 32'h1000_0000 + {22'd0, rom_addr};

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'h1000_0000 + ((a >> 2) & 32'h3FF);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural state derived from the control rules.
   logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4;
   logic        m_valid, m_halted, m_mis;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pc = 32'h0; m_instr = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0;
         m_valid = 1'b0; m_halted = 1'b0; m_mis = 1'b0;
      end else begin
         logic [31:0] old_pc;
         old_pc = m_pc;
         if (redirect && !m_halted && redirect_pc[1:0] != 2'b00) m_mis = 1'b1;
         if (m_halted || halt || flush) begin
            m_instr = 32'h0; m_ifpc = 32'h0; m_ifpc4 = 32'h0; m_valid = 1'b0;
         end else if (!stall) begin
            m_instr = rom_word(old_pc); m_ifpc = old_pc;
            m_ifpc4 = old_pc + 32'd4; m_valid = 1'b1;
         end
         if (!(m_halted || halt)) begin
            if (redirect) m_pc = redirect_pc & 32'hFFFF_FFFC;
            else if (!stall) m_pc = old_pc + 32'd4;
         end
         if (halt) m_halted = 1'b1;
      end
   end

   // Compare process: every falling edge while out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("pc", pc, m_pc);
         chk("rom_addr", {22'd0, rom_addr}, {22'd0, m_pc[11:2]});
         chk("if_instr", if_instr, m_instr);
         chk("if_pc", if_pc, m_ifpc);
         chk("if_pc4", if_pc4, m_ifpc4);
         chk("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
         chk("halted", {31'd0, halted}, {31'd0, m_halted});
         chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
      end
   end

   // Driver tasks
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ctl(input logic s, input logic f, input logic r,
                      input logic [31:0] rp, input logic h);
      stall = s; flush = f; redirect = r; redirect_pc = rp; halt = h;
   endtask

   initial begin
      rst_n = 1'b0;
      ctl(0, 0, 0, 32'h0, 0);
      step(3);
      chk("rst pc", pc, 32'h0);
      chk("rst if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst if_instr", if_instr, 32'h0);
      chk("rst halted", {31'd0, halted}, 32'd0);
      chk("rst misalign", {31'd0, misalign_err}, 32'd0);
      rst_n = 1'b1;

      // Sequential fetch
      step(1);
      chk("seq0 instr", if_instr, 32'h1000_0000);
      chk("seq0 if_pc4", if_pc4, 32'h4);
      chk("seq0 valid", {31'd0, if_valid}, 32'd1);
      step(1);
      chk("seq1 instr", if_instr, 32'h1000_0001);
      chk("seq1 pc", pc, 32'h8);

      // Stall two cycles at pc=8
      ctl(1, 0, 0, 32'h0, 0);
      step(2);
      chk("stall pc", pc, 32'h8);
      chk("stall if_pc", if_pc, 32'h4);
      chk("stall instr", if_instr, 32'h1000_0001);
      ctl(0, 0, 0, 32'h0, 0);
      step(1);
      chk("resume instr", if_instr, 32'h1000_0002);
      chk("resume pc", pc, 32'hC);

      // Redirect + flush at pc=12
      ctl(0, 1, 1, 32'h40, 0);
      step(1);
      chk("flush valid", {31'd0, if_valid}, 32'd0);
      chk("flush instr", if_instr, 32'h0);
      chk("redir pc", pc, 32'h40);
      chk("redir rom_addr", {22'd0, rom_addr}, 32'd16);
      ctl(0, 0, 0, 32'h0, 0);
      step(1);
      chk("redir if_pc", if_pc, 32'h40);
      chk("redir instr", if_instr, 32'h1000_0010);

      // Stall + misaligned redirect together
      ctl(1, 0, 1, 32'h22, 0);
      step(1);
      chk("stallredir pc", pc, 32'h20);
      chk("stallredir if_pc", if_pc, 32'h40);
      chk("misalign set", {31'd0, misalign_err}, 32'd1);
      ctl(0, 0, 1, 32'h100, 0);
      step(1);
      chk("misalign sticky", {31'd0, misalign_err}, 32'd1);
      chk("aligned pc", pc, 32'h100);
      ctl(0, 0, 0, 32'h0, 0);
      step(1);
      chk("alias-free instr", if_instr, 32'h1000_0040);

      // Wrap at top of address space
      ctl(0, 0, 1, 32'hFFFF_FFFC, 0);
      step(1);
      chk("top rom_addr", {22'd0, rom_addr}, 32'h3FF);
      ctl(0, 0, 0, 32'h0, 0);
      step(1);
      chk("wrap pc", pc, 32'h0);
      chk("wrap rom_addr", {22'd0, rom_addr}, 32'h0);
      chk("wrap if_pc4", if_pc4, 32'h0);
      chk("wrap instr", if_instr, 32'h1000_03FF);

      // Halt one cycle, then try to disturb it
      ctl(0, 0, 0, 32'h0, 1);
      step(1);
      chk("halt halted", {31'd0, halted}, 32'd1);
      chk("halt valid", {31'd0, if_valid}, 32'd0);
      chk("halt pc", pc, 32'h0);
      for (int i = 0; i < 10; i++) begin
         ctl(i[0], i[1], ~i[0], 32'h80 + (i * 4), 0);
         step(1);
      end
      ctl(0, 0, 0, 32'h0, 0);
      chk("frozen pc", pc, 32'h0);
      chk("frozen halted", {31'd0, halted}, 32'd1);

      // Reset clears halt; then async reset mid-run
      rst_n = 1'b0;
      #1;
      chk("rst clears halt", {31'd0, halted}, 32'd0);
      step(1);
      rst_n = 1'b1;
      step(3);
      chk("run pc", pc, 32'hC);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async pc", pc, 32'h0);
      chk("async valid", {31'd0, if_valid}, 32'd0);
      chk("async misalign", {31'd0, misalign_err}, 32'd0);
      step(1);
      rst_n = 1'b1;
      step(1);
      chk("post-rst if_pc", if_pc, 32'h0);
      chk("post-rst instr", if_instr, 32'h1000_0000);
      step(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
